// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: geometry, bus widths and the arbiter state type.
// Used by the display top, the scanout logic and the framebuffer port arbiter.
package fb_pkg;

    localparam int ADDR_W         = 15;
    localparam int DATA_W         = 32;
    localparam int WORDS_PER_LINE = 20;
    localparam int FB_LINES       = 480;
    localparam int FB_WORDS       = FB_LINES * WORDS_PER_LINE;
    localparam int FIFO_DEPTH     = 4;

    // IDLE: normal service; DRAIN: host stalled while queued writes retire;
    // CLEAR: fill engine walking the whole framebuffer.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } fb_arb_state_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO holding pending host writes as {addr, data}.
// The head entry is presented combinationally so the arbiter can issue it
// in the same cycle it decides to pop.
module fb_wr_fifo #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              do_push;
    logic              do_pop;

    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // Entry storage: written on push only.
    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Sole owner of the single-port 1bpp framebuffer RAM. Each cycle at most one RAM
// operation is issued, chosen by fixed priority: scanout fetch, then the oldest
// queued host write, then the next word of a full-screen clear.
module fb_port_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 32,
    parameter int FB_WORDS   = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    // host Avalon slave
    input  logic              chipselect,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writedata,
    output logic              waitrequest,
    // scanout fetch
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    // clear engine control
    input  logic              clear_start,
    input  logic [DATA_W-1:0] clear_value,
    output logic              clear_busy,
    output logic              clear_done,
    output logic [15:0]       drop_count,
    // framebuffer RAM
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    import fb_pkg::*;

    localparam logic [ADDR_W-1:0] WORD_LIMIT = ADDR_W'(FB_WORDS);
    localparam logic [ADDR_W-1:0] LAST_WORD  = ADDR_W'(FB_WORDS - 1);

    fb_arb_state_t     state;
    logic [ADDR_W-1:0] clear_ptr;
    logic [DATA_W-1:0] clear_word;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    logic              host_accept;
    logic              addr_in_range;
    logic              grant_host;
    logic              grant_clear;
    logic              clear_last;

    logic              rd_stage1;
    logic              rd_stage2;

    // Stall depends only on registered state, so there is no input-to-output path.
    assign waitrequest   = fifo_full | (state != IDLE);
    assign host_accept   = chipselect & write & ~waitrequest;
    assign addr_in_range = (address < WORD_LIMIT);
    assign fifo_push     = host_accept & addr_in_range;

    // Fixed priority: a fetch always wins the slot, host writes beat the clear engine.
    assign grant_host  = ~fetch_req & ~fifo_empty;
    assign grant_clear = ~fetch_req & fifo_empty & (state == CLEAR);
    assign fifo_pop    = grant_host;
    assign clear_last  = grant_clear & (clear_ptr == LAST_WORD);

    fb_wr_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_addr (address),
        .push_data (writedata),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_addr (head_addr),
        .head_data (head_data)
    );

    // Register the granted operation onto the RAM port; address holds when the slot is unused.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
        end else if (fetch_req) begin
            ram_addr  <= fetch_addr;
            ram_we    <= 1'b0;
        end else if (grant_host) begin
            ram_addr  <= head_addr;
            ram_wdata <= head_data;
            ram_we    <= 1'b1;
        end else if (grant_clear) begin
            ram_addr  <= clear_ptr;
            ram_wdata <= clear_word;
            ram_we    <= 1'b1;
        end else begin
            ram_we    <= 1'b0;
        end
    end

    // Fetch pipeline: address on RAM at N+1, data back at N+2, registered out at N+3.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_stage1   <= 1'b0;
            rd_stage2   <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
        end else begin
            rd_stage1   <= fetch_req;
            rd_stage2   <= rd_stage1;
            fetch_valid <= rd_stage2;
            if (rd_stage2) fetch_data <= ram_rdata;
        end
    end

    // Count host writes that fall outside the framebuffer, saturating at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count <= '0;
        end else if (host_accept && !addr_in_range && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end

    // Clear sequencer: drain queued host writes, then fill every word with the latched value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            clear_ptr  <= '0;
            clear_word <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state      <= DRAIN;
                        clear_word <= clear_value;
                        clear_ptr  <= '0;
                        clear_busy <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) state <= CLEAR;
                end
                CLEAR: begin
                    if (grant_clear) begin
                        clear_ptr <= clear_ptr + 1'b1;
                        if (clear_last) begin
                            state      <= IDLE;
                            clear_busy <= 1'b0;
                            clear_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    clear_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
